ram_stream_reader: RTL and testbench

Streaming read engine on the read port of the team's single-clock simple-dual-port RAM. It accepts a command (start address, word count) and issues one-cycle-latency reads on the RAM's enb/addrb/doutb port. Returned words are presented as a valid/ready stream with a last marker, at one word per clock when the consumer does not stall. It is the reader counterpart to the RAM's write-port producers and sits between a RAM instance and a downstream stream consumer.

---
 rtl/ram_stream_reader.sv | 140 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streaming read engine for the RAM read port: turns (addr, len) commands into a
// valid/ready word stream with a last marker, one word per clock when unstalled.
module ram_stream_reader #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LW-1:0]    cmd_len,
  output logic             enb,
  output logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] doutb,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                     r_state;
  logic [AW-1:0]              r_addr;
  logic [LW-1:0]              r_remaining;
  logic                       r_done;
  logic                       r_inflight;
  logic                       r_inflight_last;
  logic [1:0][WIDTH-1:0]      r_buf_data;
  logic [1:0]                 r_buf_last;
  logic                       r_rd_ptr;
  logic                       r_wr_ptr;
  logic [1:0]                 r_occ;

  logic                       w_pop;
  logic                       w_pop_buf;
  logic                       w_push;
  logic [2:0]                 w_credit;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign addrb     = r_addr;

  // The word returning from the RAM is presented directly when the buffer is empty.
  assign m_valid   = (r_occ != 2'd0) || r_inflight;
  assign w_pop     = m_valid & m_ready;
  assign w_pop_buf = w_pop & (r_occ != 2'd0);
  assign w_push    = r_inflight & ~(w_pop & (r_occ == 2'd0));
  assign w_credit  = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  assign enb       = (r_state == S_READ) && (w_credit < 3'd2);

  always_comb begin
    m_data = '0;
    m_last = 1'b0;
    if (r_occ != 2'd0) begin
      m_data = r_buf_data[r_rd_ptr];
      m_last = r_buf_last[r_rd_ptr];
    end else if (r_inflight) begin
      m_data = doutb;
      m_last = r_inflight_last;
    end
  end

  // Command sequencing: address pointer, remaining count, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
            if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (enb) begin
            r_addr      <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
            r_remaining <= r_remaining - LW'(1);
            if (r_remaining == LW'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && m_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read return path and 2-entry output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_buf_data      <= '0;
      r_buf_last      <= '0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_occ           <= 2'd0;
    end else begin
      r_inflight      <= enb;
      r_inflight_last <= enb && (r_remaining == LW'(1));
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= doutb;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop_buf);
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM, expected-beat queue model with a
// per-cycle compare process, and directed literal timing checks.
module tb_ram_stream_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic             enb;
  logic [AW-1:0]    addrb;
  logic [WIDTH-1:0] doutb = '0;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .enb(enb), .addrb(addrb),
    .doutb(doutb), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int k = 0; k < DEPTH; k++) mem[k] = 8'(k + 16);
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int enb_total = 0;
  int pop_total = 0;
  always @(posedge clk) cyc++;

  logic [WIDTH-1:0] exp_data [$];
  logic             exp_last [$];
  logic [AW-1:0]    exp_addr [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected-beat and expected-address queues.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  int               issued = 0;
  int               popped = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (enb) begin
        enb_total++;
        issued++;
        if (exp_addr.size() == 0) chk("enb_unexpected", 32'(enb), 32'd0);
        else chk("addrb_seq", 32'(addrb), 32'(exp_addr.pop_front()));
      end
      if (m_valid && m_ready) begin
        pop_total++;
        popped++;
        if (exp_data.size() == 0) chk("beat_unexpected", 32'(m_valid), 32'd0);
        else begin
          chk("beat_data", 32'(m_data), 32'(exp_data.pop_front()));
          chk("beat_last", 32'(m_last), 32'(exp_last.pop_front()));
        end
      end
      if (enb || (m_valid && m_ready)) chk("outstanding_le2", 32'(issued - popped <= 2), 32'd1);
      if (done) chk("done_with_beats_left", 32'(exp_data.size() + exp_addr.size()), 32'd0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic issue(input int addr, input int len);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!cmd_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = (AW+1)'(len);
    @(posedge clk);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'((addr + i) % DEPTH));
      exp_data.push_back(mem[(addr + i) % DEPTH]);
      exp_last.push_back(i == len - 1);
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_enb"},       32'(enb),       32'd0);
    chk({tag, "_addrb"},     32'(addrb),     32'd0);
    chk({tag, "_m_valid"},   32'(m_valid),   32'd0);
    chk({tag, "_m_data"},    32'(m_data),    32'd0);
    chk({tag, "_m_last"},    32'(m_last),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  int snap;
  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // addr 5 len 1
    snap = enb_total;
    issue(5, 1);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_enb", 32'(enb), 32'd1);
    chk("t1_addrb", 32'(addrb), 32'd5);
    chk("t1_mvalid_early", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_mvalid", 32'(m_valid), 32'd1);
    chk("t1_data", 32'(m_data), 32'h15);
    chk("t1_last", 32'(m_last), 32'd1);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_one_enb", 32'(enb_total - snap), 32'd1);

    // addr 0 len 4, full rate
    issue(0, 4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(m_valid), 32'd1);
      chk("t2_data", 32'(m_data), 32'(8'h10 + i));
      chk("t2_last", 32'(m_last), 32'(i == 3));
    end
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);

    // same command with stalls
    snap = pop_total;
    issue(0, 4);
    for (int i = 0; i < 7; i++) begin
      m_ready = pat[i];
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_done();
    chk("t3_beats", 32'(pop_total - snap), 32'd4);

    // wrap at end of RAM
    issue(254, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_addrb", 32'(addrb), (i < 2) ? 32'(254 + i) : 32'(i - 2));
    end
    issue_check_wrap: begin
    end
    wait_done();

    // zero length
    snap = enb_total;
    issue(7, 0);
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mvalid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t5_done_pulse", 32'(done), 32'd0);
    chk("t5_no_enb", 32'(enb_total - snap), 32'd0);

    // full-depth command
    snap = pop_total;
    issue(0, 256);
    wait_done();
    chk("t6_beats", 32'(pop_total - snap), 32'd256);

    // reset mid-burst with two words held
    m_ready = 1'b0;
    issue(10, 8);
    repeat (3) @(negedge clk);
    chk("t7_held_valid", 32'(m_valid), 32'd1);
    chk("t7_held_data", 32'(m_data), 32'h1A);
    chk("t7_no_enb", 32'(enb), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    repeat (3) begin
      @(negedge clk);
      chk("t7_no_done_in_rst", 32'(done), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t7_no_done_after", 32'(done), 32'd0);
    end
    issue(100, 3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_data", 32'(m_data), 32'(8'h74 + i));
      chk("t7_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    chk("t7_done", 32'(done), 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
